// File: rtl/memory_game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_game_pkg
// Purpose  : Types and constants shared by the memory tester game and its
//            automatic player.
// Contents : DIGIT_W              - width of one displayed digit
//            auto_player_state_t  - auto player state encoding
// Revision : 1.0 - initial release
// ============================================================================
package memory_game_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SETUP   = 3'd2,
        PUNCH   = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5
    } auto_player_state_t;

endpackage
`default_nettype wire

// File: rtl/auto_player_seq_buf.sv
`default_nettype none
// ============================================================================
// Module   : auto_player_seq_buf
// Purpose  : DEPTH x DIGIT_W register file holding the captured digit
//            sequence. The data array has no reset; the owner of the write
//            and read indices resets those instead.
// Ports    : clock   in   rising-edge clock
//            wr_en   in   write strobe
//            wr_idx  in   write index
//            wr_data in   digit to store
//            rd_idx  in   read index
//            rd_data out  combinational read of entry rd_idx
// Revision : 1.0 - initial release
// ============================================================================
module auto_player_seq_buf
    import memory_game_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_idx,
    input  logic [DIGIT_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_idx,
    output logic [DIGIT_W-1:0] rd_data
);

    logic [DIGIT_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/memory_auto_player.sv
`default_nettype none
// ============================================================================
// Module   : memory_auto_player
// Purpose  : Watches the game's flash display, stores each flashed digit and,
//            once the display has stayed blank long enough, replays the
//            sequence on the answer inputs with a set-up / punch / gap cadence.
// Ports    : clock          in   rising-edge clock
//            rst            in   asynchronous active-low reset
//            start          in   one-cycle pulse, arms capture for a level
//            flash_num      in   game display, 0 = blank
//            win, loose     in   game result, aborts to DONE
//            toggle_answer  out  answer value presented to the game
//            punch_button   out  one-cycle answer strobe
//            busy           out  capturing or replaying
//            done           out  replay finished or aborted
//            overflow       out  sticky, more than DEPTH digits flashed
//            captured_count out  number of digits stored (saturates)
// Revision : 1.0 - initial release
// ============================================================================
module memory_auto_player
    import memory_game_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int IDLE_CYCLES  = 64,
    parameter int SETUP_CYCLES = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIGIT_W-1:0]       flash_num,
    input  logic                     win,
    input  logic                     loose,
    output logic [DIGIT_W-1:0]       toggle_answer,
    output logic                     punch_button,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   captured_count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int IW     = $clog2(IDLE_CYCLES + 1);
    localparam int PMAX   = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int PW     = $clog2(PMAX + 1);

    localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);
    localparam logic [IW-1:0] C_IDLE       = IW'(IDLE_CYCLES);
    localparam logic [PW-1:0] C_SETUP_LAST = PW'(SETUP_CYCLES - 1);
    localparam logic [PW-1:0] C_GAP_LAST   = PW'(GAP_CYCLES - 1);

    auto_player_state_t r_state, w_state_nxt;

    logic [DIGIT_W-1:0] r_prev;
    logic [AW-1:0]      r_rd_idx, w_rd_nxt, w_rd_sel;
    logic [IW-1:0]      r_idle_cnt, w_idle_nxt;
    logic [PW-1:0]      r_phase_cnt, w_phase_nxt;
    logic [CW-1:0]      w_count_nxt;
    logic [DIGIT_W-1:0] w_toggle_nxt, w_rd_data;
    logic               w_ovf_nxt, w_punch_nxt, w_wr_en;
    logic               w_event, w_abort, w_busy_nxt, w_done_nxt;

    // A digit is captured only on its first displayed cycle.
    assign w_event = (flash_num != '0) && (r_prev == '0);
    assign w_abort = win | loose;

    // toggle_answer is only loaded on SETUP entry: from CAPTURE that is
    // entry 0, from GAP it is the entry after the current one.
    assign w_rd_sel = (r_state == GAP) ? (r_rd_idx + AW'(1)) : '0;

    auto_player_seq_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clock   (clock),
        .wr_en   (w_wr_en),
        .wr_idx  (captured_count[AW-1:0]),
        .wr_data (flash_num),
        .rd_idx  (w_rd_sel),
        .rd_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = captured_count;
        w_ovf_nxt    = overflow;
        w_rd_nxt     = r_rd_idx;
        w_idle_nxt   = r_idle_cnt;
        w_phase_nxt  = r_phase_cnt;
        w_toggle_nxt = toggle_answer;
        w_punch_nxt  = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt  = CAPTURE;
                    w_count_nxt  = '0;
                    w_ovf_nxt    = 1'b0;
                    w_rd_nxt     = '0;
                    w_idle_nxt   = '0;
                    w_toggle_nxt = '0;
                end
            end
            CAPTURE: begin
                if (w_abort) begin
                    w_state_nxt = DONE;
                end else begin
                    if (w_event) begin
                        if (captured_count < C_DEPTH) begin
                            w_wr_en     = 1'b1;
                            w_count_nxt = captured_count + CW'(1);
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                    end
                    if (flash_num != '0) begin
                        w_idle_nxt = '0;
                    end else if (captured_count != '0) begin
                        w_idle_nxt = r_idle_cnt + IW'(1);
                        if (w_idle_nxt == C_IDLE) begin
                            w_state_nxt  = SETUP;
                            w_rd_nxt     = '0;
                            w_phase_nxt  = '0;
                            w_toggle_nxt = w_rd_data;
                        end
                    end
                end
            end
            SETUP: begin
                if (w_abort) begin
                    w_state_nxt = DONE;
                end else if (r_phase_cnt == C_SETUP_LAST) begin
                    w_state_nxt = PUNCH;
                    w_punch_nxt = 1'b1;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase_cnt + PW'(1);
                end
            end
            PUNCH: begin
                if (w_abort) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = GAP;
                    w_phase_nxt = '0;
                end
            end
            GAP: begin
                if (w_abort) begin
                    w_state_nxt = DONE;
                end else if (r_phase_cnt == C_GAP_LAST) begin
                    if ({1'b0, r_rd_idx} == (captured_count - CW'(1))) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt  = SETUP;
                        w_rd_nxt     = w_rd_sel;
                        w_phase_nxt  = '0;
                        w_toggle_nxt = w_rd_data;
                    end
                end else begin
                    w_phase_nxt = r_phase_cnt + PW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == CAPTURE) || (w_state_nxt == SETUP) ||
                        (w_state_nxt == PUNCH)   || (w_state_nxt == GAP);
    assign w_done_nxt = (w_state_nxt == DONE);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_prev         <= '0;
            r_rd_idx       <= '0;
            r_idle_cnt     <= '0;
            r_phase_cnt    <= '0;
            captured_count <= '0;
            overflow       <= 1'b0;
            toggle_answer  <= '0;
            punch_button   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            r_prev         <= flash_num;
            r_rd_idx       <= w_rd_nxt;
            r_idle_cnt     <= w_idle_nxt;
            r_phase_cnt    <= w_phase_nxt;
            captured_count <= w_count_nxt;
            overflow       <= w_ovf_nxt;
            toggle_answer  <= w_toggle_nxt;
            punch_button   <= w_punch_nxt;
            busy           <= w_busy_nxt;
            done           <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_auto_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_auto_player
// Purpose  : Self-checking bench for memory_auto_player. Stimulus pushes the
//            digits the player should replay into a queue; a monitor pops and
//            compares on every punch. Level timing is checked from recorded
//            punch cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_auto_player;

    localparam int DEPTH   = 16;
    localparam int IDLE_C  = 64;
    localparam int PERIOD  = 3;

    logic       clock = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] flash_num;
    logic       win;
    logic       loose;
    logic [3:0] toggle_answer;
    logic       punch_button;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [4:0] captured_count;

    memory_auto_player #(
        .DEPTH        (DEPTH),
        .IDLE_CYCLES  (IDLE_C),
        .SETUP_CYCLES (1),
        .GAP_CYCLES   (1)
    ) dut (
        .clock          (clock),
        .rst            (rst),
        .start          (start),
        .flash_num      (flash_num),
        .win            (win),
        .loose          (loose),
        .toggle_answer  (toggle_answer),
        .punch_button   (punch_button),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .captured_count (captured_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    int   exp_q[$];
    int   punch_cyc[$];
    int   lvl[$];
    logic [3:0] prev_toggle = '0;
    logic       prev_punch  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every punch must carry the next expected digit,
    // be a single-cycle strobe and follow a cycle of stable toggle_answer.
    always @(negedge clock) begin
        if (rst === 1'b1 && punch_button === 1'b1) begin
            punch_cyc.push_back(cyc);
            chk("punch_width", {31'd0, prev_punch}, 0);
            chk("setup_hold", {28'd0, toggle_answer}, {28'd0, prev_toggle});
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL punch_unexpected: got punch of %0d expected none (cycle %0d)",
                         toggle_answer, cyc);
            end else begin
                chk("punch_digit", {28'd0, toggle_answer}, exp_q.pop_front());
            end
        end
        prev_toggle = toggle_answer;
        prev_punch  = punch_button;
    end

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    // Starts a level and flashes every digit in lvl with random hold and
    // blank lengths. Returns the cycle of the last non-blank display.
    task automatic drive_level(input int hl, input int hh, input int gl, input int gh,
                               output int last_nz);
        exp_q.delete();
        punch_cyc.delete();
        last_nz = 0;
        pulse_start();
        chk("start_busy", {31'd0, busy}, 1);
        chk("start_done", {31'd0, done}, 0);
        chk("start_count", {27'd0, captured_count}, 0);
        chk("start_toggle", {28'd0, toggle_answer}, 0);
        chk("start_ovf", {31'd0, overflow}, 0);
        foreach (lvl[i]) begin
            int h = $urandom_range(hh, hl);
            int g = $urandom_range(gh, gl);
            if (i < DEPTH) exp_q.push_back(lvl[i]);
            for (int k = 0; k < h; k++) begin
                flash_num = 4'(lvl[i]);
                last_nz   = cyc;
                @(posedge clock); #1;
            end
            flash_num = 4'd0;
            for (int k = 0; k < g; k++) begin
                @(posedge clock); #1;
            end
        end
    endtask

    // Waits for replay to finish and checks count, overflow and cadence.
    task automatic finish_level(input int last_nz, input bit start_mid);
        int  n    = lvl.size();
        int  ec   = (n > DEPTH) ? DEPTH : n;
        int  t    = 0;
        bit  sent = 1'b0;
        int  done_cyc;
        while (done !== 1'b1 && t < 600) begin
            @(negedge clock);
            t++;
            if (start_mid && !sent && punch_button === 1'b1) begin
                start = 1'b1;
                sent  = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start    = 1'b0;
        done_cyc = cyc;
        if (t >= 600) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got done=%0d expected 1 within 600 cycles", done);
        end
        chk("count", {27'd0, captured_count}, ec);
        chk("overflow", {31'd0, overflow}, (n > DEPTH) ? 1 : 0);
        chk("busy_at_done", {31'd0, busy}, 0);
        chk("punch_total", punch_cyc.size(), ec);
        chk("scoreboard_empty", exp_q.size(), 0);
        if (punch_cyc.size() > 0) begin
            chk("first_punch_cycle", punch_cyc[0], last_nz + IDLE_C + 2);
            for (int i = 1; i < punch_cyc.size(); i++)
                chk("punch_spacing", punch_cyc[i] - punch_cyc[i-1], PERIOD);
            chk("done_cycle", done_cyc, punch_cyc[punch_cyc.size()-1] + 2);
        end
    endtask

    task automatic abort_run(input bit use_win);
        int last_nz;
        int k = 0;
        int t = 0;
        lvl = '{3, 9, 1, 12, 6};
        drive_level(2, 2, 1, 1, last_nz);
        while (k < 3 && t < 300) begin
            @(negedge clock);
            t++;
            if (punch_button === 1'b1) k++;
        end
        chk("abort_reached_3rd", k, 3);
        if (use_win) win = 1'b1; else loose = 1'b1;
        @(negedge clock);
        win   = 1'b0;
        loose = 1'b0;
        chk(use_win ? "win_done" : "loose_done", {31'd0, done}, 1);
        chk(use_win ? "win_busy" : "loose_busy", {31'd0, busy}, 0);
        chk(use_win ? "win_punch" : "loose_punch", {31'd0, punch_button}, 0);
        repeat (20) @(negedge clock);
        chk(use_win ? "win_no_more" : "loose_no_more", punch_cyc.size(), 3);
        chk("abort_done_held", {31'd0, done}, 1);
        exp_q.delete();
    endtask

    initial begin
        int last_nz;
        int k;
        rst = 1'b0; start = 1'b0; win = 1'b0; loose = 1'b0; flash_num = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_toggle", {28'd0, toggle_answer}, 0);
        chk("rst_punch", {31'd0, punch_button}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_count", {27'd0, captured_count}, 0);
        rst = 1'b1;

        // Nominal sequence.
        lvl = '{4, 8, 5, 7, 6, 8, 15};
        drive_level(3, 3, 2, 2, last_nz);
        finish_level(last_nz, 1'b0);

        // A long hold and a repeated digit are each captured once.
        lvl = '{8, 8};
        drive_level(10, 10, 1, 1, last_nz);
        finish_level(last_nz, 1'b0);

        // Overflow: 17 flashes, only 16 kept.
        lvl.delete();
        for (int i = 0; i < 17; i++) lvl.push_back((i % 15) + 1);
        drive_level(1, 3, 1, 3, last_nz);
        finish_level(last_nz, 1'b0);

        // Random levels, some with a start pulse during replay.
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(20, 1);
            lvl.delete();
            for (int i = 0; i < n; i++) lvl.push_back($urandom_range(15, 1));
            drive_level(1, 4, 1, 3, last_nz);
            finish_level(last_nz, (r % 2) == 1);
        end

        abort_run(1'b0);
        abort_run(1'b1);

        // Reset in the middle of replay.
        lvl = '{2, 11, 5, 9, 14, 1};
        drive_level(2, 2, 1, 2, last_nz);
        k = 0;
        for (int t = 0; t < 300 && k < 2; t++) begin
            @(negedge clock);
            if (punch_button === 1'b1) k++;
        end
        #2 rst = 1'b0;
        #1;
        chk("midrst_toggle", {28'd0, toggle_answer}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_count", {27'd0, captured_count}, 0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        rst = 1'b1;
        repeat (10) @(negedge clock);
        chk("after_rst_idle_busy", {31'd0, busy}, 0);
        chk("after_rst_idle_punch", {31'd0, punch_button}, 0);
        lvl = '{7, 3, 10};
        drive_level(1, 3, 1, 2, last_nz);
        finish_level(last_nz, 1'b0);

        // No digits: stays in capture, then win ends the level.
        punch_cyc.delete();
        exp_q.delete();
        pulse_start();
        repeat (150) @(posedge clock);
        #1;
        chk("nodigit_busy", {31'd0, busy}, 1);
        chk("nodigit_done", {31'd0, done}, 0);
        chk("nodigit_count", {27'd0, captured_count}, 0);
        chk("nodigit_punches", punch_cyc.size(), 0);
        win = 1'b1;
        @(posedge clock); #1 win = 1'b0;
        chk("nodigit_win_done", {31'd0, done}, 1);
        chk("nodigit_win_busy", {31'd0, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_auto_player.md
# memory_auto_player

Automated player for the memory tester game. It watches the game's `flash_num` display during the flash phase and stores each flashed digit in a small buffer. After the display goes idle, it replays the stored sequence on the game's `toggle_answer` / `punch_button` answer inputs, using the same set-up / punch / release cadence a human player produces. It sits beside `game_module` as the answering end of the flash/answer interface and is used for self-test and regression of the game.

## Interface
Parameters:
- `DEPTH`, 16: maximum number of digits stored.
- `IDLE_CYCLES`, 64: cycles of blank display, after at least one captured digit, that end the capture phase.
- `SETUP_CYCLES`, 1: cycles `toggle_answer` is stable before the punch.
- `GAP_CYCLES`, 1: cycles after the punch before the next digit is driven.

Ports:
- `clock`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; arms capture for a new level.
- `flash_num`  in  4  game display. 0 means blank; each digit is non-zero and separated from the next by at least one blank cycle.
- `win`  in  1  game reports win.
- `loose`  in  1  game reports loss.
- `toggle_answer`  out  4  answer value presented to the game.
- `punch_button`  out  1  one-cycle answer strobe.
- `busy`  out  1  high in CAPTURE/SETUP/PUNCH/GAP.
- `done`  out  1  high in DONE.
- `overflow`  out  1  sticky; more than `DEPTH` digits were flashed.
- `captured_count`  out  $clog2(DEPTH)+1  number of digits stored.

## Operation
- All outputs are registered. Reset value of every output is 0; reset state is IDLE. Reset clears the buffer pointers and the `prev` register.
- `prev` holds the previous cycle's `flash_num` and updates every cycle in every state. A capture event is `flash_num != 0 && prev == 0`.
- States and transitions:
  - **IDLE / DONE:** on `start`, go to CAPTURE. Clear `captured_count`, `overflow`, read index, idle counter and `toggle_answer`. A digit already on display when `start` arrives is not captured.
  - **CAPTURE:**
    - On a capture event with `captured_count < DEPTH`: write the digit at index `captured_count`, then increment.
    - On a capture event with `captured_count == DEPTH`: drop the digit and set `overflow`.
    - Idle counter: increments while `flash_num == 0` and `captured_count >= 1`; clears on any non-zero `flash_num`.
    - When the idle counter reaches `IDLE_CYCLES`, go to SETUP with read index 0.
    - With `captured_count == 0` there is no timeout.
  - **SETUP:** `toggle_answer` = buffer[read index], driven on entry. Hold `SETUP_CYCLES` cycles with `punch_button` low, then go to PUNCH.
  - **PUNCH:** exactly one cycle, `punch_button` = 1, `toggle_answer` held.
  - **GAP:** `GAP_CYCLES` cycles with `punch_button` low and `toggle_answer` held. Then:
    - if read index == `captured_count` - 1, go to DONE;
    - otherwise increment read index and go to SETUP.
  - **DONE:** `done` = 1. `toggle_answer` keeps its last value until the next `start`.
- `win` or `loose` high in any of CAPTURE/SETUP/PUNCH/GAP: go to DONE on the next edge. `punch_button` is 0 from that edge. Priority: `win`/`loose` over idle timeout and over a capture event in the same cycle.
- `start` while `busy` is ignored.
- Width rules: `captured_count` saturates at `DEPTH`. Read index and idle counter never wrap within a level.

## Timing
- Capture latency: a digit appearing in cycle N is written at the edge ending cycle N. `captured_count` reflects it in cycle N+1.
- Timeout: the first SETUP cycle is the cycle after the idle counter reaches `IDLE_CYCLES`.
- Punch period per digit: `SETUP_CYCLES` + 1 + `GAP_CYCLES` cycles, which is 3 with defaults. `toggle_answer` changes only on SETUP entry, one cycle before the punch with defaults.
- `done` rises on the edge after the last GAP cycle, or on the edge after `win`/`loose`.
- Reset mid-operation: all outputs drop asynchronously to 0. The block restarts in IDLE.

## Structure
- Shared package `memory_game_pkg`:
  - `DIGIT_W` = 4;
  - state enum `auto_player_state_t` (IDLE, CAPTURE, SETUP, PUNCH, GAP, DONE).
  - `game_module` uses `DIGIT_W` from the same package.
- One sub-module, `auto_player_seq_buf`: `DEPTH` x `DIGIT_W` register file with write enable, write index, read index and combinational read. It has no reset on the data, only on its pointer inputs' owners.
- The top level holds the FSM, `prev`, the idle/setup/gap counters and the output registers.

## Test plan
- **Reset:** hold `rst` = 0 mid-replay. All outputs are 0 immediately, state is IDLE, and a later `start` works normally.
- **Nominal capture and replay:** `start`, then flash 4, 8, 5, 7, 6, 8, 15, each for 3 cycles with 2 blank cycles between, then blank. Required: `captured_count` = 7; after 64 blank cycles, `toggle_answer` shows 4, 8, 5, 7, 6, 8, 15 with `punch_button` pulses exactly 3 cycles apart; `done` = 1 one cycle after the 7th GAP.
- **Repeats and holds:** digit 8 for 10 cycles, blank, then 8 again. Required: captured twice, not 10 times; `captured_count` = 2.
- **Overflow:** 17 distinct flashes with `DEPTH` = 16. Required: `overflow` = 1, `captured_count` = 16, 16 punches replayed.
- **Abort:** `loose` = 1 during the third PUNCH cycle. Required: no further `punch_button` pulses, `done` = 1 next cycle, `busy` = 0. Repeat the scenario with `win`.
- **Ignored start and no-digit level:** `start` during replay is ignored and replay continues. `start` followed by a permanently blank display leaves the block in CAPTURE indefinitely, with `busy` = 1 and no punches.
